flash_read_arbiter: RTL and testbench
=====================================

Name: flash_read_arbiter

Overview:
Shares the single fixed-latency flash read port between two requesters. Requester 0 is the network controller's weight/bias fetch path. Requester 1 is the SPI readback/debug path. The arbiter accepts one request at a time with round-robin priority, issues the flash read strobe and address, waits out the flash latency, captures the data, and returns it to the granted requester with a one-cycle valid pulse.

Parameters:
ADDR_W, 16, flash address width
DATA_W, 16, flash data width
LATENCY, 11, cycles from the flash_ready strobe cycle to valid flashData_out (minimum 1)

Ports:
clk  input  1  clock
n_rst  input  1  asynchronous active-low reset
req0  input  1  requester 0 read request, held until gnt0
addr0  input  ADDR_W  requester 0 address, valid while req0
gnt0  output  1  requester 0 accepted (one-cycle pulse)
rvalid0  output  1  rdata valid for requester 0 (one-cycle pulse)
req1  input  1  requester 1 read request, held until gnt1
addr1  input  ADDR_W  requester 1 address, valid while req1
gnt1  output  1  requester 1 accepted (one-cycle pulse)
rvalid1  output  1  rdata valid for requester 1 (one-cycle pulse)
rdata  output  DATA_W  captured flash data, shared by both requesters
flash_ready  output  1  flash read strobe
flash_address  output  ADDR_W  flash read address
flashData_out  input  DATA_W  flash read data
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset is n_rst, asynchronous, active-low; clock is clk.
- Reset values: state=IDLE; gnt0/gnt1/rvalid0/rvalid1/flash_ready=0; flash_address=0; rdata=0; last_owner pointer=1, so requester 0 wins the first tie.
- States and transitions:
  - IDLE -> ISSUE when req0|req1.
  - ISSUE -> WAIT after 1 cycle.
  - WAIT -> RETURN after exactly LATENCY cycles.
  - RETURN -> IDLE after 1 cycle.
- Arbitration in IDLE:
  - Only one request: grant it.
  - Both requests: grant the requester that is not last_owner.
  - gnt is combinational (Mealy) in the IDLE cycle. The selected address is latched into flash_address, owner and last_owner are updated, and all of this happens at the same clock edge.
- ISSUE: flash_ready=1 for exactly one cycle. flash_address is stable from ISSUE until the next grant; it holds the last issued address.
- WAIT: a latency counter of width clog2(LATENCY+1) is cleared in ISSUE and increments each WAIT cycle. On the last WAIT cycle (the LATENCY-th cycle after ISSUE), flashData_out is captured into rdata.
- RETURN: rvalid of the owner is 1 for one cycle; the other rvalid stays 0. rdata holds until the next capture.
- Timing: grant at cycle 0, strobe at cycle 1, capture at the end of cycle 1+LATENCY, rvalid at cycle 2+LATENCY, IDLE at 3+LATENCY. Max throughput is one read per LATENCY+3 cycles. With LATENCY=11: rvalid at cycle 13, next grant no earlier than cycle 14.
- Requests arriving while busy are not granted. They stay pending because the requester holds req and addr, and are arbitrated in the next IDLE cycle.
- A request held high after its rvalid is a new request.
- Deassertion of req after gnt has no effect on the in-flight access.
- Reset mid-access (any state): return immediately to reset values. No rvalid is produced for the aborted access, and flash_ready drops at once.
- At most one access is in flight at any time. gnt0 and gnt1 are never high together, and neither are rvalid0 and rvalid1.

Test Plan:
1. Single read: req0=1 with addr0=0x0010; flash model drives 0xBEEF at strobe+11 -> gnt0 at cycle 0, flash_ready=1 with flash_address=0x0010 at cycle 1, rvalid0=1 with rdata=0xBEEF at cycle 13, busy=0 at cycle 14.
2. Tie after reset: req0 and req1 both raised at cycle 0 (addr0=0x0100, addr1=0x0200) -> gnt0 at cycle 0, gnt1 at cycle 14, flash_address=0x0200 at cycle 15, rvalid1 at cycle 27.
3. Round-robin fairness: req0 and req1 held continuously for 4 accesses -> grant order 0,1,0,1; no rvalid on the non-owner.
4. Late arrival: req1 raised at cycle 5 while req0's access is busy -> gnt1 is not asserted until cycle 14; its address is latched then.
5. Reset mid-WAIT: n_rst pulled low at cycle 6 of a req0 access -> flash_ready=0, rvalid0 never pulses, flash_address=0; a new req0 after reset completes normally with rvalid0 13 cycles after its grant.
6. Parameter check at LATENCY=1: req1 at 0x0003 -> strobe at cycle 1, capture at the end of cycle 2, rvalid1 at cycle 3, IDLE at cycle 4.

Source files
------------

// File: rtl/flash_read_arbiter.sv
// ----------------------------------------------------------------------------
// flash_read_arbiter
//
// Shares one fixed-latency flash read port between two requesters:
//   requester 0 - network controller weight/bias fetch path
//   requester 1 - SPI readback/debug path
//
// One access is in flight at a time. An idle arbiter grants a request
// combinationally (round-robin on ties), strobes the flash for one cycle,
// waits LATENCY cycles, captures the data and returns it to the owner with
// a one-cycle rvalid pulse.
//
// Timeline of one access (cycle 0 = grant):
//   0            gnt (combinational), address latched at end of cycle
//   1            flash_ready strobe
//   2..1+LATENCY wait, data captured at end of cycle 1+LATENCY
//   2+LATENCY    rvalid of the owner
//   3+LATENCY    idle again, next grant possible
//
// Parameters:
//   ADDR_W   flash address width
//   DATA_W   flash data width
//   LATENCY  cycles from the strobe cycle to valid flashData_out (>= 1)
//
// Ports:
//   clk, n_rst            clock, asynchronous active-low reset
//   req0/addr0            requester 0 request (held until gnt0) and address
//   gnt0, rvalid0         requester 0 accept pulse and data-valid pulse
//   req1/addr1            requester 1 request (held until gnt1) and address
//   gnt1, rvalid1         requester 1 accept pulse and data-valid pulse
//   rdata                 captured flash data, shared by both requesters
//   flash_ready           flash read strobe
//   flash_address         flash read address, held until the next grant
//   flashData_out         flash read data
//   busy                  high whenever an access is in progress
// ----------------------------------------------------------------------------
module flash_read_arbiter #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned LATENCY = 11
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              flash_ready,
    output logic [ADDR_W-1:0] flash_address,
    input  logic [DATA_W-1:0] flashData_out,
    output logic              busy
);

    localparam int unsigned      CNT_W    = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StReturn
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_next;
    // The owner of the in-flight access is always the most recent grantee,
    // so one bit serves as both owner and round-robin pointer.
    logic                r_last_owner;
    logic [ADDR_W-1:0]   r_flash_address;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_idle;
    logic                w_grant0;
    logic                w_grant1;
    logic                w_capture;

    // ------------------------------------------------------------------
    // Arbitration (Mealy, only in idle)
    // ------------------------------------------------------------------
    assign w_idle = (r_state == StIdle);

    // A tie goes to the requester that did not own the previous access.
    // n_rst gating keeps both grants low while reset is held.
    assign w_grant0 = w_idle & n_rst & req0 & (~req1 | r_last_owner);
    assign w_grant1 = w_idle & n_rst & req1 & (~req0 | ~r_last_owner);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_grant0 || w_grant1) begin
                    w_state_next = StIssue;
                end
            end
            StIssue: begin
                w_state_next = StWait;
                w_cnt_next   = '0;
            end
            StWait: begin
                w_cnt_next = r_cnt + CNT_W'(1);
                // r_cnt counts completed wait cycles; this is the LATENCY-th.
                if (r_cnt == CNT_LAST) begin
                    w_capture    = 1'b1;
                    w_state_next = StReturn;
                end
            end
            StReturn: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state         <= StIdle;
            r_cnt           <= '0;
            r_last_owner    <= 1'b1;
            r_flash_address <= '0;
            r_rdata         <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_grant0 || w_grant1) begin
                r_last_owner    <= w_grant1;
                r_flash_address <= w_grant1 ? addr1 : addr0;
            end
            if (w_capture) begin
                r_rdata <= flashData_out;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign gnt0          = w_grant0;
    assign gnt1          = w_grant1;
    assign flash_ready   = (r_state == StIssue);
    assign rvalid0       = (r_state == StReturn) & ~r_last_owner;
    assign rvalid1       = (r_state == StReturn) &  r_last_owner;
    assign busy          = ~w_idle;
    assign flash_address = r_flash_address;
    assign rdata         = r_rdata;

    // ------------------------------------------------------------------
    // Protocol invariants
    // ------------------------------------------------------------------
    a_gnt_exclusive: assert property (@(posedge clk) disable iff (!n_rst)
        !(gnt0 && gnt1));
    a_rvalid_exclusive: assert property (@(posedge clk) disable iff (!n_rst)
        !(rvalid0 && rvalid1));

endmodule

// File: tb/tb_flash_read_arbiter.sv
module tb_flash_read_arbiter;

    localparam int L = 11;

    logic        clk   = 1'b0;
    logic        n_rst = 1'b0;
    logic        req0  = 1'b0;
    logic        req1  = 1'b0;
    logic [15:0] addr0 = '0;
    logic [15:0] addr1 = '0;
    logic [15:0] flashData_out = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1, flash_ready, busy;
    logic [15:0] rdata, flash_address;

    // Second instance at LATENCY=1
    logic        b_req0  = 1'b0;
    logic        b_req1  = 1'b0;
    logic [15:0] b_addr0 = '0;
    logic [15:0] b_addr1 = '0;
    logic [15:0] b_fdata = 16'hFFFF;
    logic        b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_flash_ready, b_busy;
    logic [15:0] b_rdata, b_flash_address;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    flash_read_arbiter #(.ADDR_W(16), .DATA_W(16), .LATENCY(L)) u_dut (
        .clk(clk), .n_rst(n_rst),
        .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0),
        .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1),
        .rdata(rdata), .flash_ready(flash_ready), .flash_address(flash_address),
        .flashData_out(flashData_out), .busy(busy)
    );

    flash_read_arbiter #(.ADDR_W(16), .DATA_W(16), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .n_rst(n_rst),
        .req0(b_req0), .addr0(b_addr0), .gnt0(b_gnt0), .rvalid0(b_rvalid0),
        .req1(b_req1), .addr1(b_addr1), .gnt1(b_gnt1), .rvalid1(b_rvalid1),
        .rdata(b_rdata), .flash_ready(b_flash_ready), .flash_address(b_flash_address),
        .flashData_out(b_fdata), .busy(b_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, 32'(act), 32'(exp));
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        check(name, 32'(act), 32'(exp));
    endtask

    // Flash contents; 0x0010 holds 0xBEEF
    function automatic logic [15:0] flash_mem(input logic [15:0] a);
        if (a == 16'h0010) return 16'hBEEF;
        return {a[7:0], a[15:8]} ^ 16'hC35A;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: m_p = cycles since the current grant, -1 when free
    // ------------------------------------------------------------------
    int          m_p     = -1;
    logic        m_last  = 1'b1;
    logic [15:0] m_addr  = '0;
    logic [15:0] m_rdata = '0;

    function automatic logic want0();
        return n_rst && (m_p < 0) && req0 && (!req1 || m_last);
    endfunction

    function automatic logic want1();
        return n_rst && (m_p < 0) && req1 && (!req0 || !m_last);
    endfunction

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_p     <= -1;
            m_last  <= 1'b1;
            m_addr  <= '0;
            m_rdata <= '0;
        end else if (m_p < 0) begin
            if (want0()) begin
                m_p    <= 1;
                m_last <= 1'b0;
                m_addr <= addr0;
            end else if (want1()) begin
                m_p    <= 1;
                m_last <= 1'b1;
                m_addr <= addr1;
            end
        end else begin
            if (m_p == L + 1) m_rdata <= flashData_out;
            m_p <= (m_p == L + 2) ? -1 : m_p + 1;
        end
    end

    // Flash: valid data only in the LATENCY-th cycle after the strobe, noise otherwise
    always @(posedge clk) begin
        #1;
        if (m_p == L + 1) flashData_out = flash_mem(m_addr);
        else              flashData_out = 16'($urandom);
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        check1("gnt0", gnt0, want0());
        check1("gnt1", gnt1, want1());
        check1("rvalid0", rvalid0, n_rst && (m_p == L + 2) && !m_last);
        check1("rvalid1", rvalid1, n_rst && (m_p == L + 2) && m_last);
        check1("flash_ready", flash_ready, m_p == 1);
        check1("busy", busy, m_p >= 1);
        check16("flash_address", flash_address, m_addr);
        check16("rdata", rdata, m_rdata);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_now();
        n_rst = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        #1;
        check1("rst_gnt0", gnt0, 1'b0);
        check1("rst_gnt1", gnt1, 1'b0);
        check1("rst_rvalid0", rvalid0, 1'b0);
        check1("rst_rvalid1", rvalid1, 1'b0);
        check1("rst_flash_ready", flash_ready, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check16("rst_flash_address", flash_address, 16'h0000);
        check16("rst_rdata", rdata, 16'h0000);
        adv(2);
        n_rst = 1'b1;
    endtask

    logic g0, g1;

    initial begin
        adv(1);
        reset_now();

        // Single read
        req0 = 1'b1; addr0 = 16'h0010; #1;
        check1("t1_gnt0_c0", gnt0, 1'b1);
        check1("t1_busy_c0", busy, 1'b0);
        adv(1); req0 = 1'b0; #1;
        check1("t1_ready_c1", flash_ready, 1'b1);
        check16("t1_addr_c1", flash_address, 16'h0010);
        adv(12); #1;
        check1("t1_rvalid0_c13", rvalid0, 1'b1);
        check1("t1_rvalid1_c13", rvalid1, 1'b0);
        check16("t1_rdata_c13", rdata, 16'hBEEF);
        adv(1); #1;
        check1("t1_busy_c14", busy, 1'b0);
        check16("t1_rdata_hold", rdata, 16'hBEEF);

        // Tie after reset
        reset_now();
        req0 = 1'b1; addr0 = 16'h0100; req1 = 1'b1; addr1 = 16'h0200; #1;
        check1("t2_gnt0_c0", gnt0, 1'b1);
        check1("t2_gnt1_c0", gnt1, 1'b0);
        adv(1); req0 = 1'b0;
        adv(13); #1;
        check1("t2_gnt1_c14", gnt1, 1'b1);
        adv(1); req1 = 1'b0; #1;
        check16("t2_addr_c15", flash_address, 16'h0200);
        check1("t2_ready_c15", flash_ready, 1'b1);
        adv(12); #1;
        check1("t2_rvalid1_c27", rvalid1, 1'b1);
        check1("t2_rvalid0_c27", rvalid0, 1'b0);
        adv(1);

        // Round-robin with both held
        req0 = 1'b1; addr0 = 16'h1111; req1 = 1'b1; addr1 = 16'h2222;
        for (int k = 0; k < 4; k++) begin
            #1;
            check1("t3_rr_gnt0", gnt0, (k % 2) == 0);
            check1("t3_rr_gnt1", gnt1, (k % 2) == 1);
            adv(14);
        end
        req0 = 1'b0; req1 = 1'b0;

        // Late arrival of req1
        req0 = 1'b1; addr0 = 16'h0A0A; #1;
        check1("t4_gnt0_c0", gnt0, 1'b1);
        adv(1); req0 = 1'b0;
        adv(4); req1 = 1'b1; addr1 = 16'h0B0B; #1;
        check1("t4_gnt1_c5", gnt1, 1'b0);
        adv(9); #1;
        check1("t4_gnt1_c14", gnt1, 1'b1);
        adv(1); req1 = 1'b0; #1;
        check16("t4_addr_c15", flash_address, 16'h0B0B);
        adv(13);

        // Reset mid-WAIT
        req0 = 1'b1; addr0 = 16'h0C0C; #1;
        check1("t5_gnt0_c0", gnt0, 1'b1);
        adv(1); req0 = 1'b0;
        adv(5);
        reset_now();
        for (int k = 0; k < 15; k++) begin
            adv(1); #1;
            check1("t5_no_rvalid0", rvalid0, 1'b0);
        end
        adv(1);
        req0 = 1'b1; addr0 = 16'h0D0D; #1;
        check1("t5_gnt0_new", gnt0, 1'b1);
        adv(1); req0 = 1'b0;
        adv(12); #1;
        check1("t5_rvalid0_c13", rvalid0, 1'b1);
        check16("t5_rdata_c13", rdata, flash_mem(16'h0D0D));
        adv(1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            g0 = gnt0;
            g1 = gnt1;
            @(posedge clk); #1;
            if (!req0) begin
                if ($urandom_range(0, 2) == 0) begin req0 = 1'b1; addr0 = 16'($urandom); end
            end else if (g0) begin
                if ($urandom_range(0, 1) == 0) req0 = 1'b0;
                else                           addr0 = 16'($urandom);
            end
            if (!req1) begin
                if ($urandom_range(0, 2) == 0) begin req1 = 1'b1; addr1 = 16'($urandom); end
            end else if (g1) begin
                if ($urandom_range(0, 1) == 0) req1 = 1'b0;
                else                           addr1 = 16'($urandom);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        adv(20);

        // LATENCY=1 instance
        b_req1 = 1'b1; b_addr1 = 16'h0003; b_fdata = 16'h1111; #1;
        check1("t6_gnt1_c0", b_gnt1, 1'b1);
        check1("t6_busy_c0", b_busy, 1'b0);
        adv(1); b_req1 = 1'b0; #1;
        check1("t6_ready_c1", b_flash_ready, 1'b1);
        check16("t6_addr_c1", b_flash_address, 16'h0003);
        adv(1); b_fdata = 16'h5A5A; #1;
        check1("t6_busy_c2", b_busy, 1'b1);
        check1("t6_ready_c2", b_flash_ready, 1'b0);
        check1("t6_rvalid1_c2", b_rvalid1, 1'b0);
        adv(1); b_fdata = 16'h1234; #1;
        check1("t6_rvalid1_c3", b_rvalid1, 1'b1);
        check1("t6_rvalid0_c3", b_rvalid0, 1'b0);
        check16("t6_rdata_c3", b_rdata, 16'h5A5A);
        adv(1); #1;
        check1("t6_busy_c4", b_busy, 1'b0);
        check1("t6_rvalid1_c4", b_rvalid1, 1'b0);
        check16("t6_rdata_hold", b_rdata, 16'h5A5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
